// File: rtl/bht_pkg.sv
// Shared defaults, FSM state type and constants for the branch history table write side.
// The statistics counters are built only when BHT_STATS_EN is defined.
package bht_pkg;

  localparam int ROWS_DEF  = 8;
  localparam int CNT_W_DEF = 16;
  localparam int PC_W_DEF  = 32;

  localparam int unsigned PC_INC = 4;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } bht_state_e;

endpackage

// File: rtl/bht_victim_sel.sv
// Combinational argmax over packed row ages with an exclude mask; ties go to the
// lowest index and the result is one-hot (all zero only if every row is excluded).
module bht_victim_sel #(
  parameter int ROWS  = 8,
  parameter int CNT_W = 16
) (
  input  logic [ROWS*CNT_W-1:0] row_count,
  input  logic [ROWS-1:0]       exclude,
  output logic [ROWS-1:0]       victim
);

  logic [CNT_W-1:0] best_val;
  logic             found;

  // Strict greater-than keeps the earliest row on equal ages.
  always_comb begin
    victim   = '0;
    best_val = '0;
    found    = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      if (!exclude[i] && (!found || (row_count[CNT_W*i +: CNT_W] > best_val))) begin
        victim    = '0;
        victim[i] = 1'b1;
        best_val  = row_count[CNT_W*i +: CNT_W];
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bht_alloc_ctrl.sv
// EX-stage write controller for the branch history table: allocation, row update and redirect.
// Define BHT_STATS_EN to build the saturating branch/mispredict counters.
module bht_alloc_ctrl
  import bht_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  stall,
  input  logic                  ex_branch,
  input  logic                  ex_taken,
  input  logic [PC_W-1:0]       ex_pc,
  input  logic [PC_W-1:0]       ex_target,
  input  logic                  ex_pred_jump,
  input  logic [PC_W-1:0]       ex_pred_target,
  input  logic [ROWS*CNT_W-1:0] row_count,
  input  logic [ROWS-1:0]       row_ex_hit,
  output logic [ROWS-1:0]       write_row,
  output logic                  upd_branch,
  output logic                  upd_taken,
  output logic [PC_W-1:0]       upd_pc,
  output logic [PC_W-1:0]       write_data,
  output logic                  redirect,
  output logic [PC_W-1:0]       redirect_pc,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispred
);

  bht_state_e      state_q, state_d;
  logic            accept, hit, mispredict, alloc;
  logic [ROWS-1:0] victim;

  assign accept = ex_valid & ex_branch & ~stall & (state_q == RUN);

  // A row written last cycle has not yet been absorbed by the array, so match it here.
  assign hit = (|row_ex_hit) | ((write_row != '0) && (ex_pc == upd_pc));

  assign mispredict = (ex_taken != ex_pred_jump) |
                      (ex_taken & ex_pred_jump & (ex_target != ex_pred_target));

  assign alloc = ~hit & ex_taken;

  bht_victim_sel #(
    .ROWS  (ROWS),
    .CNT_W (CNT_W)
  ) u_victim_sel (
    .row_count (row_count),
    .exclude   (write_row),
    .victim    (victim)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && mispredict) state_d = SQUASH;
      SQUASH:  if (!stall) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Strobes pulse only after an accept; data outputs hold between accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_row   <= '0;
      upd_branch  <= 1'b0;
      upd_taken   <= 1'b0;
      upd_pc      <= '0;
      write_data  <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      upd_branch <= accept;
      redirect   <= accept & mispredict;
      write_row  <= (accept && alloc) ? victim : '0;
      if (accept) begin
        upd_taken   <= ex_taken;
        upd_pc      <= ex_pc;
        redirect_pc <= ex_taken ? ex_target : ex_pc + PC_W'(PC_INC);
      end
      if (accept && alloc) write_data <= ex_target;
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] branches_q, mispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else if (accept) begin
      if (branches_q != 32'hFFFF_FFFF) branches_q <= branches_q + 32'd1;
      if (mispredict && (mispred_q != 32'hFFFF_FFFF)) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign stat_branches = branches_q;
  assign stat_mispred  = mispred_q;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: doc/bht_alloc_ctrl.md
# bht_alloc_ctrl

Write-side controller for the branch history table. It sits at the EX stage and resolves each conditional branch against the prediction carried from IF. It chooses a victim row when a taken branch misses every row and drives the one-hot row write strobes plus aligned state-update signals into the row array. It also raises a one-cycle front-end redirect on misprediction.

## Interface
- ROWS, 8, number of table rows (2..16)
- PC_W, 32, PC and target width
- CNT_W, 16, per-row age field width; MSB set means row invalid
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX holds a real instruction this cycle
- stall  in  1  pipeline frozen; EX inputs are repeated and must be ignored
- ex_branch  in  1  EX instruction is a conditional branch
- ex_taken  in  1  resolved outcome
- ex_pc  in  PC_W  branch PC
- ex_target  in  PC_W  resolved taken target
- ex_pred_jump  in  1  IF prediction (taken)
- ex_pred_target  in  PC_W  IF predicted target
- row_count  in  ROWS*CNT_W  packed row ages, row i at [CNT_W*i+CNT_W-1 : CNT_W*i]
- row_ex_hit  in  ROWS  row i tag matches ex_pc
- write_row  out  ROWS  one-hot row write strobe
- upd_branch  out  1  branch update to rows, aligned with write_row
- upd_taken  out  1  outcome to rows (Branch_Success)
- upd_pc  out  PC_W  PC presented to rows as EX PC during update
- write_data  out  PC_W  target written into the selected row
- redirect  out  1  flush and refetch strobe
- redirect_pc  out  PC_W  refetch address
- stat_branches  out  32  resolved branch count (see Configuration)
- stat_mispred  out  32  mispredict count (see Configuration)

## Operation
- Accept condition in cycle t: ex_valid & ex_branch & !stall & state==RUN.
- hit = |row_ex_hit, or the pending-write bypass: write_row!=0 and ex_pc==upd_pc. The rows have not yet absorbed that write.
- mispredict = (ex_taken != ex_pred_jump) | (ex_taken & ex_pred_jump & ex_target != ex_pred_target).
- Victim selection:
  - Pick the row with the largest row_count value, unsigned compare, so invalid rows win.
  - Ties go to the lowest index.
  - The row currently strobed by write_row is excluded, because its age is about to reset.
- Registered outputs at t+1:
  - upd_branch=1, upd_taken=ex_taken, upd_pc=ex_pc.
  - write_row=onehot(victim) and write_data=ex_target only if !hit & ex_taken; otherwise write_row=0.
  - redirect=mispredict.
  - redirect_pc = ex_taken ? ex_target : ex_pc+4, truncated to PC_W.
- If the accept condition is false, every strobe (upd_branch, write_row, redirect) is 0 next cycle. Data outputs hold their previous values.
- FSM:
  - RUN: after an accept with mispredict, go to SQUASH.
  - SQUASH: lasts one cycle. EX holds a wrong-path instruction, so no accept occurs; return to RUN.
  - stall in SQUASH holds SQUASH.
- Not-taken misses never allocate a row.

## Timing
- Fixed latency of 1 cycle from accept to strobes. All strobes are single-cycle pulses.
- Back-to-back accepts are allowed, one per cycle in RUN.
- Reset has priority over all other logic. After reset:
  - all outputs = 0
  - state = RUN
  - stat counters = 0
- Reset asserted mid-operation drops any pending strobe in the same edge.
- A mispredict accepted in cycle t gives redirect at t+1 and no accept at t+1. The next accept is possible at t+2.

## Configuration
- BHT_STATS_EN defined:
  - stat_branches increments on every accept.
  - stat_mispred increments on every accept with mispredict.
  - Both saturate at 32'hFFFFFFFF.
- BHT_STATS_EN undefined: no counter logic is built, both ports are tied to 0, and the ports remain present.

## Structure
- Package bht_pkg holds:
  - ROWS_DEF, CNT_W_DEF, PC_W_DEF
  - the FSM state enum {RUN, SQUASH}
  - the PC increment constant (4)
- Sub-module bht_victim_sel: combinational argmax over row_count with an exclude mask; tie goes to lowest index; outputs a one-hot.

## Test plan
- ROWS=8, all rows invalid (counts 16'h8000); taken miss at pc 0x100, target 0x200 -> next cycle write_row=8'h01, write_data=0x200, upd_taken=1, redirect=1, redirect_pc=0x200.
- Row 2 hits at pc 0x100 with pred_jump=1 and pred_target=0x200; actual taken to 0x200 -> write_row=0, upd_branch=1, redirect=0.
- Predicted taken, actual not taken at pc 0x100 -> redirect=1, redirect_pc=0x104. The next-cycle EX branch is ignored (no upd_branch).
- Two consecutive taken misses at the same pc 0x300 -> only one write_row pulse is issued; the second accept sees a bypass hit.
- Counts {r0=5, r1=9, r2=9, others 0}, with r1 being written this cycle; a new taken miss -> victim is r2 (write_row=8'h04).
- rst asserted in the cycle after an accept -> write_row, upd_branch, and redirect all read 0. With BHT_STATS_EN, 3 accepts with 1 mispredict -> stat_branches=3, stat_mispred=1.
